// File: rtl/bram18_frame_reader_pkg.sv
// Shared constants and FSM encodings for the BRAM18 read-side sequencer.
package bram18_frame_reader_pkg;

   localparam int DEPTH_A   = 2048;
   localparam int NUM_WORDS = DEPTH_A / 4;
   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_RUN   = 2'd1,
      RD_DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/bram18_rd_fifo2.sv
// Two-entry register FIFO between the BRAM read port and the output stream.
// The head entry is read straight from storage, so it holds still while stalled.
module bram18_rd_fifo2 #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   // storage, pointers and occupancy update
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/bram18_frame_reader.sv
// Read-side sequencer for the BRAM18 line buffer: walks ADDR_B 0..NUM_WORDS-1,
// absorbs the one-cycle read latency and streams words out with backpressure.
// Optional feature macro: BRAM_RD_TLAST_EN adds o_m_last on the final word.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RD_IDLE  | waiting for i_start (also hosts the DONE cycle, busy still 1)
// RD_RUN   | issuing reads whenever the FIFO has room for the result
// RD_DRAIN | all reads issued; waiting for the last word to be accepted
module bram18_frame_reader
   import bram18_frame_reader_pkg::*;
(
   input  logic              i_clk_b,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_addr_b,
   output logic              o_en_b,
   input  logic [DATA_W-1:0] i_dout_b,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready
`ifdef BRAM_RD_TLAST_EN
   ,output logic             o_m_last
`endif
);

`ifdef BRAM_RD_TLAST_EN
   localparam int FIFO_W = DATA_W + 1;
`else
   localparam int FIFO_W = DATA_W;
`endif

   rd_state_t         r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_done;
   logic              r_inflight;
`ifdef BRAM_RD_TLAST_EN
   logic              r_inflight_last;
`endif

   logic [1:0]        w_occ;
   logic              w_pop;
   logic [2:0]        w_level;
   logic              w_en;
   logic [FIFO_W-1:0] w_fifo_din;
   logic [FIFO_W-1:0] w_fifo_dout;

   assign o_m_valid = (w_occ != 2'd0);
   assign w_pop     = o_m_valid & i_m_ready;
   // Words already owed to the FIFO after this cycle's pop; a new read may only
   // be issued if its result is guaranteed a slot when it lands.
   assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_en      = (r_state == RD_RUN) && (w_level < 3'd2);

`ifdef BRAM_RD_TLAST_EN
   assign w_fifo_din = {r_inflight_last, i_dout_b};
   assign o_m_last   = w_fifo_dout[DATA_W] & o_m_valid;
`else
   assign w_fifo_din = i_dout_b;
`endif
   assign o_m_data = w_fifo_dout[DATA_W-1:0];

   assign o_en_b   = w_en;
   assign o_addr_b = r_addr;
   assign o_busy   = r_busy;
   assign o_done   = r_done;

   bram18_rd_fifo2 #(
      .DATA_W (FIFO_W)
   ) u_fifo (
      .i_clk   (i_clk_b),
      .i_rst   (i_rst),
      .i_push  (r_inflight),
      .i_data  (w_fifo_din),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_count (w_occ)
   );

   // sequencer FSM, address counter and in-flight tracking
   always_ff @(posedge i_clk_b) begin
      if (i_rst) begin
         r_state    <= RD_IDLE;
         r_addr     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_inflight <= 1'b0;
`ifdef BRAM_RD_TLAST_EN
         r_inflight_last <= 1'b0;
`endif
      end else begin
         r_inflight <= w_en;
`ifdef BRAM_RD_TLAST_EN
         r_inflight_last <= w_en && (r_addr == LAST_ADDR);
`endif
         r_done <= 1'b0;
         case (r_state)
            RD_IDLE: begin
               // busy is still high during the DONE cycle, so a start there is dropped
               if (r_done) begin
                  r_busy <= 1'b0;
               end else if (i_start && !r_busy) begin
                  r_state <= RD_RUN;
                  r_busy  <= 1'b1;
                  r_addr  <= '0;
               end
            end
            RD_RUN: begin
               if (w_en) begin
                  if (r_addr == LAST_ADDR) begin
                     r_state <= RD_DRAIN;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            RD_DRAIN: begin
               // nothing left in flight and the sole remaining entry leaves now
               if (!r_inflight && (w_occ == 2'd1) && w_pop) begin
                  r_state <= RD_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram18_frame_reader.sv
// Scoreboard bench for bram18_frame_reader with a behavioural BRAM read port.
module tb_bram18_frame_reader;
   import bram18_frame_reader_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready;
   logic        busy;
   logic        done;
   logic        en_b;
   logic        m_valid;
   logic [8:0]  addr_b;
   logic [31:0] dout_b = '0;
   logic [31:0] m_data;
`ifdef BRAM_RD_TLAST_EN
   logic        m_last;
`endif

   always #5 clk = ~clk;

   bram18_frame_reader dut (
      .i_clk_b   (clk),
      .i_rst     (rst),
      .i_start   (start),
      .o_busy    (busy),
      .o_done    (done),
      .o_addr_b  (addr_b),
      .o_en_b    (en_b),
      .i_dout_b  (dout_b),
      .o_m_data  (m_data),
      .o_m_valid (m_valid),
      .i_m_ready (ready)
`ifdef BRAM_RD_TLAST_EN
      ,.o_m_last (m_last)
`endif
   );

   logic [7:0] bmem [0:2047];

   function automatic logic [31:0] word(input int k);
      return {bmem[k+1536], bmem[k+1024], bmem[k+512], bmem[k]};
   endfunction

   task automatic load(input int mode);
      for (int a = 0; a < 2048; a++) begin
         case (mode)
            0:       bmem[a] = 8'(a % 256);
            1:       bmem[a] = 8'((a + 61 * (a / 512)) % 256);
            default: bmem[a] = 8'((255 - (a % 256)) ^ ((a / 512) * 51));
         endcase
      end
   endtask

   always @(posedge clk) if (en_b) dout_b <= word(int'(addr_b));

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int tot_iss  = 0;
   int tot_hs   = 0;
   int tot_done = 0;
   int base_iss = 0;
   int base_hs  = 0;

   // monitor: checks every issued read and every accepted word
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      int          pend;
      exp_t        e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(m_valid), 32'd1);
               check("stall_data", m_data, prev_data);
            end
            if (en_b) begin
               check("addr_order", 32'(addr_b), 32'(tot_iss - base_iss));
               pend = (tot_iss - base_iss) - (tot_hs - base_hs);
               if (m_valid && ready) pend--;
               check("no_overflow", 32'(pend < 2), 32'd1);
               tot_iss++;
            end
            if (m_valid && ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_word", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("word_data", m_data, e.data);
`ifdef BRAM_RD_TLAST_EN
                  check("m_last", 32'(m_last), 32'(e.last));
`endif
               end
               tot_hs++;
            end
            if (done) tot_done++;
            prev_stall = m_valid && !ready;
            prev_data  = m_data;
         end
      end
   end

   logic [15:0] pat = 16'b1011_0010_0110_1100;

   // issues START (sampled at edge t) and returns at t+1
   task automatic do_start();
      base_iss = tot_iss;
      base_hs  = tot_hs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         exp_t e;
         e.data = word(k);
         e.last = (k == NUM_WORDS - 1);
         sb_q.push_back(e);
      end
   endtask

   task automatic run_to_done(input int n0, input int limit, input logic use_pat,
                              input int busy_start_at, input logic start_on_done,
                              output int n);
      n = n0;
      while (!done && n < limit) begin
         if (use_pat) ready = pat[n % 16];
         start = (n == busy_start_at);
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
      check("done_reached", 32'(done), 32'd1);
      if (done) check("busy_on_done", 32'(busy), 32'd1);
      if (start_on_done && done) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         check("start_on_done_busy", 32'(busy), 32'd0);
         check("start_on_done_en", 32'(en_b), 32'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      check({tag, "_en_b"},    32'(en_b),    32'd0);
      check({tag, "_addr_b"},  32'(addr_b),  32'd0);
      check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_m_data"},  m_data,       32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      int i0;
      rst   = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      load(0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // pass 1: ready held high, cycle-exact timing
      ready = 1'b1;
      d0 = tot_done;
      do_start();
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_en_b", 32'(en_b), 32'd1);
      check("t1_addr_b", 32'(addr_b), 32'd0);
      @(posedge clk);
      #1;
      check("t2_m_valid", 32'(m_valid), 32'd0);
      @(posedge clk);
      #1;
      check("t3_m_valid", 32'(m_valid), 32'd1);
      check("t3_word0", m_data, 32'h0000_0000);
      run_to_done(3, 2000, 1'b0, -1, 1'b0, n);
      check("done_cycle", 32'(n), 32'd515);
      @(posedge clk);
      #1;
      check("p1_busy_after", 32'(busy), 32'd0);
      check("p1_done_pulse", 32'(done), 32'd0);
      check("p1_sb_empty", 32'(sb_q.size()), 32'd0);
      check("p1_done_count", 32'(tot_done - d0), 32'd1);

      // pass 2: patterned backpressure, START while busy and on DONE
      load(1);
      d0 = tot_done;
      do_start();
      run_to_done(1, 4000, 1'b1, 50, 1'b1, n);
      ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("p2_done_count", 32'(tot_done - d0), 32'd1);
      check("p2_sb_empty", 32'(sb_q.size()), 32'd0);
      check("p2_idle_busy", 32'(busy), 32'd0);
      check("p2_idle_en", 32'(en_b), 32'd0);

      // pass 3: consumer stalled for 20 cycles after START
      load(2);
      ready = 1'b0;
      i0 = tot_iss;
      do_start();
      repeat (19) @(posedge clk);
      #1;
      check("stall_reads", 32'(tot_iss - i0), 32'd2);
      check("stall_hold_valid", 32'(m_valid), 32'd1);
      check("stall_hold_word0", m_data, word(0));
      check("stall_en_off", 32'(en_b), 32'd0);
      ready = 1'b1;
      run_to_done(20, 2000, 1'b0, -1, 1'b0, n);
      @(posedge clk);
      #1;
      check("p3_sb_empty", 32'(sb_q.size()), 32'd0);

      // pass 4: reset in the middle of the pass, then restart
      load(1);
      ready = 1'b1;
      do_start();
      n = 0;
      while ((tot_hs - base_hs) < 100 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reach_word100", 32'(tot_hs - base_hs), 32'd100);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midrst");
      rst = 1'b0;
      sb_q.delete();
      d0 = tot_done;
      i0 = tot_iss;
      repeat (10) @(posedge clk);
      #1;
      check("rst_no_done", 32'(tot_done - d0), 32'd0);
      check("rst_no_reads", 32'(tot_iss - i0), 32'd0);
      check("rst_idle_valid", 32'(m_valid), 32'd0);
      do_start();
      check("restart_addr", 32'(addr_b), 32'd0);
      check("restart_en", 32'(en_b), 32'd1);
      run_to_done(1, 2000, 1'b0, -1, 1'b0, n);
      check("restart_done_cycle", 32'(n), 32'd515);
      @(posedge clk);
      #1;
      check("p4_sb_empty", 32'(sb_q.size()), 32'd0);
      check("p4_done_count", 32'(tot_done - d0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bram18_frame_reader.md
# bram18_frame_reader

Read-side sequencer for the true dual-port BRAM18 line buffer. On a start command it walks the 9-bit read port (ADDR_B 0..511) and fetches each 32-bit packed word: 4 pixels at offsets +0/+512/+1024/+1536, lane 0 in bits [7:0]. It accounts for the one-cycle BRAM read latency and presents the words on a valid/ready stream to the downstream pixel pipeline, with full backpressure support. It sits in the CLK_B domain, between the BRAM read port and the consumer.

## Interface
- NUM_WORDS, 512: words per frame pass; equals `DEPTH_A/4.
- ADDR_W, 9: width of ADDR_B.
- CLK_B  in  1  read-domain clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin a pass; ignored while BUSY=1.
- BUSY  out  1  high from the cycle after accepted START until the DONE cycle, inclusive.
- DONE  out  1  one-cycle pulse after the last word is handshaked.
- ADDR_B  out  ADDR_W  BRAM read address.
- EN_B  out  1  BRAM read enable; high only on cycles that issue a read.
- DOUT_B  in  32  BRAM read data, valid the cycle after EN_B=1.
- M_DATA  out  32  packed word to the consumer.
- M_VALID  out  1  M_DATA valid.
- M_READY  in  1  consumer accepts when M_VALID and M_READY are both high.
- M_LAST  out  1  present only with BRAM_RD_TLAST_EN.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when START=1.
  - RUN→DRAIN on the cycle that issues address NUM_WORDS-1.
  - DRAIN→IDLE when the in-flight count is 0, the FIFO is empty, and word NUM_WORDS-1 has been popped. DONE pulses on that cycle.
- Address counter: ADDR_W bits, cleared on START, incremented per issued read. It never wraps within a pass.
- Output FIFO:
  - 2 entries.
  - Push when the registered in-flight flag is set, i.e. the cycle after EN_B=1.
  - Pop on handshake.
- Issue rule: EN_B=1 in RUN when (occupancy + inflight − pop_this_cycle) < 2. This guarantees no overflow and gives 1 word/cycle with M_READY held high.
- Order: words leave in strictly increasing address order, and no word is duplicated or dropped under any M_READY pattern.
- Reset values: all outputs 0, FSM in IDLE, FIFO and in-flight flag cleared. rst mid-pass aborts the pass, with no DONE pulse and no further EN_B. DOUT_B arriving the cycle after rst is discarded.
- START while BUSY: ignored; the pass continues unchanged.
- START in the same cycle as DONE: ignored; a new pass requires START with BUSY=0.

## Timing
- START sampled at edge t, then:
  - t+1: BUSY=1, EN_B=1, ADDR_B=0.
  - t+2: DOUT_B valid.
  - t+3: M_VALID=1 with word 0.
- M_READY held high: one word per cycle. Word 511 appears at t+514, and DONE plus the last BUSY cycle fall at t+515.
- M_READY low: M_VALID and M_DATA stay stable until the handshake. At most 2 further reads are issued, then EN_B stays 0.
- First-word latency after START: 3 cycles.

## Configuration
- BRAM_RD_TLAST_EN defined:
  - Adds the 1-bit output M_LAST.
  - M_LAST is high alongside M_VALID for word NUM_WORDS-1 only, and is carried through the FIFO as a tag bit.
- BRAM_RD_TLAST_EN undefined: no port, no tag storage. Behaviour is otherwise identical.

## Structure
- Shared package package_fpga.v holds:
  - `DEPTH_A (2048).
  - The derived words-per-pass constant (`DEPTH_A/4).
  - The FSM state encodings RD_IDLE/RD_RUN/RD_DRAIN.
- Sub-module: bram18_rd_fifo2, a 2-entry register FIFO with push/pop/occupancy, parameterised data width (32, or 33 with tag).
- Top level: FSM, address counter, in-flight flag, issue logic.

## Test plan
- Pass with M_READY=1: BRAM preloaded with byte value = address mod 256 → word k = {(k+1536)%256, (k+1024)%256, (k+512)%256, k%256}, 512 words, DONE at START+515.
- Random M_READY (50%): the 512 words arrive in order, EN_B never issues while the FIFO would overflow, and M_DATA is stable while stalled.
- M_READY=0 for 20 cycles after START: exactly 2 EN_B pulses (ADDR_B 0, 1), M_VALID held with word 0. The pass resumes correctly.
- rst asserted at word 100 of a pass: next cycle all outputs 0, no DONE. A subsequent START restarts from ADDR_B=0.
- START pulsed while BUSY and on the DONE cycle: ignored, exactly one pass and one DONE. With BRAM_RD_TLAST_EN, M_LAST is high only on word 511.
